// File: rtl/bus_sram_responder.sv
// bus_sram_responder: system-bus slave that serves single-word and burst
// reads/writes from an internal single-clock word memory mapped at a fixed
// address window. Bursts that would run past the window end are rejected
// with a one-cycle error pulse and never touch the memory.
module bus_sram_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_WIDTH   = 9
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        data_validOUT,
  output logic        end_transactionOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  // Wide enough to hold start index + burst size without wrapping.
  localparam int unsigned SUM_W = ADDR_WIDTH + 9;
  localparam logic [SUM_W-1:0]      LAST_IDX = SUM_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_FETCH = 3'd1,
    RD_DATA  = 3'd2,
    WRITE    = 3'd3,
    RD_END   = 3'd4,
    ERROR    = 3'd5
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [7:0]              cnt_q;
  logic [3:0]              be_q;
  logic                    wr_done_q;
  logic                    dv_q;
  logic                    eto_q;
  logic                    err_q;
  logic [31:0]             rd_data_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    hit_s;
  logic                    begin_hit_s;
  logic [ADDR_WIDTH-1:0]   start_idx_s;
  logic [SUM_W-1:0]        span_end_s;
  logic                    overflow_s;
  logic                    mem_we_s;
  logic                    rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_idx_d;
  logic                    unused_addr_lsb_s;

  // Window decode and burst-range check on the begin-cycle address.
  assign hit_s       = (address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
  assign begin_hit_s = begin_transactionIN & hit_s;
  assign start_idx_s = address_dataIN[ADDR_WIDTH+1:2];
  assign span_end_s  = {9'b0_0000_0000, start_idx_s} + {{(ADDR_WIDTH+1){1'b0}}, burst_sizeIN};
  assign overflow_s  = (span_end_s > LAST_IDX);

  // Byte-address low bits carry no meaning for a word memory.
  assign unused_addr_lsb_s = ^address_dataIN[1:0];

  // Write strobe: only while words of the burst remain, and never under reset.
  assign mem_we_s = (state_q == WRITE) & data_validIN & ~wr_done_q & ~system_reset;

  // Memory read request: the start word on fetch, then the next word whenever
  // the current one is accepted so the stream has no bubbles.
  always_comb begin
    rd_en_d  = 1'b0;
    rd_idx_d = idx_q;
    if (end_transactionIN) begin
      rd_en_d = 1'b0;
    end else if (state_q == RD_FETCH) begin
      rd_en_d = 1'b1;
    end else if ((state_q == RD_DATA) && !busyIN && (cnt_q != 8'd0)) begin
      rd_en_d  = 1'b1;
      rd_idx_d = idx_q + IDX_ONE;
    end else begin
      rd_en_d = 1'b0;
    end
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge system_clock) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= address_dataIN[8*b +: 8];
        end
      end
    end
  end

  // Synchronous read port driving the read-data output register.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      rd_data_q <= 32'h0000_0000;
    end else if (rd_en_d) begin
      rd_data_q <= mem_q[rd_idx_d];
    end
  end

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= 8'd0;
      be_q      <= 4'h0;
      wr_done_q <= 1'b0;
      dv_q      <= 1'b0;
      eto_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      eto_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (begin_hit_s) begin
            idx_q     <= start_idx_s;
            cnt_q     <= burst_sizeIN;
            be_q      <= byte_enableIN;
            wr_done_q <= 1'b0;
            if (overflow_s) begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end else if (read_n_writeIN) begin
              state_q <= RD_FETCH;
            end else begin
              state_q <= WRITE;
            end
          end
        end
        RD_FETCH: begin
          if (end_transactionIN) begin
            state_q <= IDLE;
          end else begin
            state_q <= RD_DATA;
            dv_q    <= 1'b1;
          end
        end
        RD_DATA: begin
          if (end_transactionIN) begin
            state_q <= IDLE;
            dv_q    <= 1'b0;
          end else if (!busyIN) begin
            if (cnt_q == 8'd0) begin
              state_q <= RD_END;
              dv_q    <= 1'b0;
              eto_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
        WRITE: begin
          if (mem_we_s) begin
            idx_q <= idx_q + IDX_ONE;
            if (cnt_q == 8'd0) begin
              wr_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          if (end_transactionIN) begin
            state_q <= IDLE;
          end
        end
        RD_END: begin
          state_q <= IDLE;
        end
        ERROR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          dv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign address_dataOUT    = rd_data_q;
  assign data_validOUT      = dv_q;
  assign end_transactionOUT = eto_q;
  assign errorOUT           = err_q;
  assign busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench for bus_sram_responder: a table of single-word vectors,
// hand-written reset/abort/stall/decode sequences, and randomized bursts
// compared against a word-array model of the memory.
module tb_bus_sram_responder;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int          WORDS = 512;

  logic        clk;
  logic        system_reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [WORDS];
  logic [31:0] wbuf  [300];

  typedef struct {
    int          kind;   // 0 write one word, 1 read one word, 2 expect error
    logic        rnw;
    logic [31:0] addr;
    int          bs;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  bus_sram_responder dut (
    .system_clock        (clk),
    .system_reset        (system_reset),
    .address_dataIN      (address_dataIN),
    .byte_enableIN       (byte_enableIN),
    .burst_sizeIN        (burst_sizeIN),
    .read_n_writeIN      (read_n_writeIN),
    .begin_transactionIN (begin_transactionIN),
    .end_transactionIN   (end_transactionIN),
    .data_validIN        (data_validIN),
    .busyIN              (busyIN),
    .address_dataOUT     (address_dataOUT),
    .data_validOUT       (data_validOUT),
    .end_transactionOUT  (end_transactionOUT),
    .busyOUT             (busyOUT),
    .errorOUT            (errorOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    address_dataIN      = 32'h0;
    byte_enableIN       = 4'h0;
    burst_sizeIN        = 8'h0;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE) >> 2;
    return int'(off);
  endfunction

  function automatic logic is_hit(input logic [31:0] addr);
    return (addr[31:11] == BASE[31:11]);
  endfunction

  task automatic chk_all_zero(input string name);
    chk(name, 32'({data_validOUT, end_transactionOUT, errorOUT, busyOUT}), 32'h0);
    chk(name, address_dataOUT, 32'h0);
  endtask

  // Write burst from wbuf; nsend may exceed bs+1 to exercise dropping.
  task automatic do_write(input logic [31:0] addr, input int bs, input logic [3:0] be,
                          input int nsend, input bit gaps);
    int idx;
    idx = widx(addr);
    begin_transactionIN = 1'b1;
    read_n_writeIN      = 1'b0;
    address_dataIN      = addr;
    burst_sizeIN        = 8'(bs);
    byte_enableIN       = be;
    tick();
    idle_inputs();
    for (int i = 0; i < nsend; i++) begin
      while (gaps && ($urandom_range(0, 3) == 0)) begin
        data_validIN = 1'b0;
        tick();
      end
      data_validIN   = 1'b1;
      address_dataIN = wbuf[i];
      if (is_hit(addr) && (i <= bs)) model[idx + i] = merge(model[idx + i], wbuf[i], be);
      tick();
      chk("wr_quiet", 32'({data_validOUT, end_transactionOUT, errorOUT}), 32'h0);
    end
    idle_inputs();
    end_transactionIN = 1'b1;
    tick();
    idle_inputs();
  endtask

  // Read burst, checking every word against the model and the handshake timing.
  task automatic do_read(input logic [31:0] addr, input int bs, input int stall_at,
                         input int stall_len, input bit rand_busy, output logic [31:0] first);
    int idx, got, stalls, held, c;
    bit done, busy, seen;
    idx = widx(addr);
    got = 0; stalls = 0; held = 0; done = 1'b0; seen = 1'b0;
    first = 32'h0;
    begin_transactionIN = 1'b1;
    read_n_writeIN      = 1'b1;
    address_dataIN      = addr;
    burst_sizeIN        = 8'(bs);
    byte_enableIN       = 4'h0;
    tick();
    idle_inputs();
    c = 1;
    while (!done && (c < 600)) begin
      busy = 1'b0;
      if (errorOUT) chk("rd_no_err", 32'(errorOUT), 32'h0);
      if (data_validOUT) begin
        if (!seen) begin
          chk("rd_first_latency", 32'(c), 32'd2);
          first = address_dataOUT;
          seen  = 1'b1;
        end
        if (got > bs) chk("rd_overrun", 32'(got), 32'(bs));
        else chk("rd_data", address_dataOUT, model[idx + got]);
        if ((got == stall_at) && (held < stall_len)) begin
          busy = 1'b1;
          held++;
        end else if (rand_busy) begin
          busy = ($urandom_range(0, 3) == 0);
        end
        if (busy) stalls++;
        else got++;
      end else if (rand_busy) begin
        busy = 1'($urandom_range(0, 1));
      end
      if (end_transactionOUT) begin
        chk("rd_end_cycle", 32'(c), 32'(3 + bs + stalls));
        chk("rd_end_count", 32'(got), 32'(bs + 1));
        chk("rd_end_dv_low", 32'(data_validOUT), 32'h0);
        done = 1'b1;
      end
      busyIN = busy;
      tick();
      c++;
    end
    busyIN = 1'b0;
    if (!done) chk("rd_timeout", 32'h0, 32'h1);
    chk("rd_after_end", 32'({data_validOUT, end_transactionOUT}), 32'h0);
  endtask

  // Begin a transaction that must be rejected with a single error pulse.
  task automatic do_error(input logic [31:0] addr, input int bs, input logic rnw);
    begin_transactionIN = 1'b1;
    read_n_writeIN      = rnw;
    address_dataIN      = addr;
    burst_sizeIN        = 8'(bs);
    byte_enableIN       = 4'hF;
    tick();
    idle_inputs();
    chk("err_pulse", 32'(errorOUT), 32'h1);
    chk("err_no_dv", 32'(data_validOUT), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_one_cycle", 32'({errorOUT, data_validOUT, end_transactionOUT}), 32'h0);
    end
  endtask

  task automatic run_random();
    int idx, maxbs, bs, kind, nsend;
    logic [31:0] addr, dummy;
    logic [3:0] be;
    for (int it = 0; it < 60; it++) begin
      idx   = $urandom_range(0, WORDS - 1);
      maxbs = WORDS - 1 - idx;
      kind  = $urandom_range(0, 9);
      addr  = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      if ((kind == 0) && (maxbs < 255)) begin
        bs = $urandom_range(maxbs + 1, 255);
        do_error(addr, bs, 1'($urandom_range(0, 1)));
      end else begin
        bs = $urandom_range(0, (maxbs < 15) ? maxbs : 15);
        if (kind < 5) begin
          be    = 4'($urandom_range(0, 15));
          nsend = bs + 1 + $urandom_range(0, 2);
          for (int i = 0; i < nsend; i++) wbuf[i] = $urandom;
          do_write(addr, bs, be, nsend, 1'b1);
        end else begin
          do_read(addr, bs, -1, 0, 1'b1, dummy);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] first;
    idle_inputs();
    system_reset = 1'b1;

    vecs[0]  = '{0, 1'b0, 32'h5000_0100, 0, 4'hF, 32'h0000_0000, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h5000_0100, 0, 4'h5, 32'hAABB_CCDD, 32'h0};
    vecs[2]  = '{1, 1'b1, 32'h5000_0100, 0, 4'h0, 32'h0,         32'h00BB_00DD};
    vecs[3]  = '{0, 1'b0, 32'h5000_0104, 0, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h5000_0104, 0, 4'hA, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1, 1'b1, 32'h5000_0104, 0, 4'h0, 32'h0,         32'h12FF_56FF};
    vecs[6]  = '{0, 1'b0, 32'h5000_07FF, 0, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[7]  = '{1, 1'b1, 32'h5000_07FC, 0, 4'h0, 32'h0,         32'hCAFE_F00D};
    vecs[8]  = '{2, 1'b1, 32'h5000_07FC, 1, 4'h0, 32'h0,         32'h0};
    vecs[9]  = '{2, 1'b0, 32'h5000_0404, 255, 4'hF, 32'h0,       32'h0};
    vecs[10] = '{1, 1'b1, 32'h5000_07FD, 0, 4'h0, 32'h0,         32'hCAFE_F00D};
    vecs[11] = '{1, 1'b1, 32'h5000_0100, 0, 4'h0, 32'h0,         32'h00BB_00DD};

    tick(); tick(); tick();
    chk_all_zero("reset_outputs");
    system_reset = 1'b0;
    tick();
    chk_all_zero("idle_outputs");

    // Give every word a known value.
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
      do_write(BASE + 32'(h * 1024), 255, 4'hF, 256, 1'b0);
    end

    // Table-driven single-word vectors.
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].kind == 0) begin
        wbuf[0] = vecs[v].wdata;
        do_write(vecs[v].addr, vecs[v].bs, vecs[v].be, 1, 1'b0);
      end else if (vecs[v].kind == 1) begin
        do_read(vecs[v].addr, vecs[v].bs, -1, 0, 1'b0, first);
        chk("vec_read", first, vecs[v].exp);
      end else begin
        do_error(vecs[v].addr, vecs[v].bs, vecs[v].rnw);
      end
    end

    // Write burst then read it back, then with busy stall on the second word.
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
    wbuf[2] = 32'h3333_3333; wbuf[3] = 32'h4444_4444;
    do_write(32'h5000_0010, 3, 4'hF, 4, 1'b0);
    do_read(32'h5000_0010, 3, -1, 0, 1'b0, first);
    chk("burst_first", first, 32'h1111_1111);
    do_read(32'h5000_0010, 3, 1, 3, 1'b0, first);

    // Decode miss: no activity, memory untouched.
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(32'h6000_0010, 0, 4'hF, 1, 1'b0);
    do_read(32'h5000_0010, 0, -1, 0, 1'b0, first);
    chk("miss_untouched", first, 32'h1111_1111);

    // Reset in the middle of a read burst.
    begin_transactionIN = 1'b1; read_n_writeIN = 1'b1;
    address_dataIN = 32'h5000_00A0; burst_sizeIN = 8'd7;
    tick(); idle_inputs();
    tick();
    chk("rst_rd_dv", 32'(data_validOUT), 32'h1);
    tick();
    system_reset = 1'b1;
    tick(); chk_all_zero("rst_rd_mid1");
    tick(); chk_all_zero("rst_rd_mid2");
    system_reset = 1'b0;
    do_read(32'h5000_00A0, 7, -1, 0, 1'b0, first);

    // Reset during a write: the word sampled with reset is not stored.
    begin_transactionIN = 1'b1; read_n_writeIN = 1'b0;
    address_dataIN = 32'h5000_00F0; burst_sizeIN = 8'd3; byte_enableIN = 4'hF;
    tick(); idle_inputs();
    data_validIN = 1'b1; address_dataIN = 32'hA5A5_0001;
    model[60] = 32'hA5A5_0001;
    tick();
    address_dataIN = 32'hA5A5_0002; system_reset = 1'b1;
    tick(); chk_all_zero("rst_wr_mid1");
    idle_inputs();
    tick(); chk_all_zero("rst_wr_mid2");
    system_reset = 1'b0;
    do_read(32'h5000_00F0, 1, -1, 0, 1'b0, first);
    chk("rst_wr_word0", first, 32'hA5A5_0001);

    // Abort during the first word of an 8-word read.
    begin_transactionIN = 1'b1; read_n_writeIN = 1'b1;
    address_dataIN = 32'h5000_0140; burst_sizeIN = 8'd7;
    tick(); idle_inputs();
    tick();
    chk("abort_dv_before", 32'(data_validOUT), 32'h1);
    end_transactionIN = 1'b1;
    tick();
    end_transactionIN = 1'b0;
    chk("abort_dv_drop", 32'(data_validOUT), 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("abort_quiet", 32'({data_validOUT, end_transactionOUT}), 32'h0);
      tick();
    end
    do_read(32'h5000_0140, 7, -1, 0, 1'b0, first);

    run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

Bus-side responder (slave) for the system bus that the JTAG DMA drives as initiator. It decodes transactions addressed to its window and serves single-word and burst reads and writes from an internal single-clock word memory. It sits on the system bus next to the arbiter. It lets the JTAG DMA path be exercised end to end against a known target.

## Interface
Parameters:
- BASE_ADDRESS, 32'h5000_0000: byte base of the window; must be aligned to 2^(ADDR_WIDTH+2).
- ADDR_WIDTH, 9: word-index width; the memory holds 2^ADDR_WIDTH 32-bit words.

Ports:
- system_clock  in  1  sole clock; all logic on its rising edge.
- system_reset  in  1  synchronous, active-high reset.
- address_dataIN  in  32  address in the begin cycle, write data afterwards.
- byte_enableIN  in  4  per-byte write enables, sampled in the begin cycle.
- burst_sizeIN  in  8  number of words minus 1, sampled in the begin cycle.
- read_n_writeIN  in  1  1 = read, 0 = write, sampled in the begin cycle.
- begin_transactionIN  in  1  one-cycle transaction start.
- end_transactionIN  in  1  initiator end/abort.
- data_validIN  in  1  write word present on address_dataIN.
- busyIN  in  1  initiator stalls read data.
- address_dataOUT  out  32  read data.
- data_validOUT  out  1  read word present.
- end_transactionOUT  out  1  one-cycle end of a read burst.
- busyOUT  out  1  responder stall; held 0, since the memory takes one word per cycle.
- errorOUT  out  1  one-cycle error pulse.

## Operation
- Hit: address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]. A miss is ignored and the FSM stays IDLE.
- Start word index: address_dataIN[ADDR_WIDTH+1:2]. The low two address bits are ignored.
- On a hit, latch the index, the remaining count (burst_size), byte enables and direction.
- Error case: start index + burst_size > 2^ADDR_WIDTH - 1 (burst crosses the window end).
  - FSM goes to ERROR and pulses errorOUT for 1 cycle.
  - No memory access; back to IDLE.
- FSM states: IDLE, RD_FETCH, RD_DATA, WRITE, RD_END, ERROR.
- IDLE:
  - begin_transactionIN with a hit and read -> RD_FETCH.
  - begin_transactionIN with a hit and write -> WRITE.
  - begin_transactionIN with a hit and the error case -> ERROR.
- RD_FETCH: synchronous memory read of the start index -> RD_DATA.
- RD_DATA: data_validOUT=1, address_dataOUT = mem[index].
  - A word is accepted in each cycle with busyIN=0.
  - On accept with count>0: decrement count, increment index; the next word appears the following cycle (one word per cycle, no bubble).
  - busyIN=1: hold data, data_validOUT and index unchanged.
  - Accept with count==0 -> RD_END.
- RD_END: end_transactionOUT=1 for 1 cycle, data_validOUT=0 -> IDLE.
- WRITE:
  - Each cycle with data_validIN=1 writes address_dataIN into mem[index]; only bytes with byte_enable set change.
  - After a write, the index increments.
  - Words beyond burst_size+1 are dropped.
  - end_transactionIN -> IDLE.
- end_transactionIN in RD_FETCH/RD_DATA aborts to IDLE next cycle:
  - data_validOUT drops.
  - No end_transactionOUT.
- Read data is always the full word; byte_enable affects writes only.
- A begin_transactionIN outside IDLE is ignored.

## Timing
- Reset: all outputs 0, FSM IDLE. Memory contents are not cleared.
- Reset asserted mid-transaction returns the FSM to IDLE on the next edge, outputs 0. An in-flight write word sampled in the same cycle is not stored.
- Read: begin at cycle T -> first data_validOUT at T+2.
- Read, busyIN held low: word n at T+2+n; end_transactionOUT at T+3+burst_size.
- Each cycle of busyIN=1 during RD_DATA delays all following words by one cycle.
- Write: data in cycle W is visible to a read fetch issued at W+1 or later.
- Error: errorOUT at T+1.

## Test plan
- Reset: assert system_reset 2 cycles mid-burst -> all outputs 0 next cycle, IDLE; next begin is served normally.
- Write then readback:
  - Write burst_size=3 at 0x5000_0010, data 0x11111111..0x44444444, byte_enable=4'hF.
  - Read back the same burst -> data_validOUT at T+2..T+5 with those words; end_transactionOUT at T+6.
- Byte enables:
  - Write 0xAABBCCDD with byte_enable=4'b0101 over a word holding 0x00000000.
  - Single read -> 0x00BB00DD.
- Read stall: 4-word read with busyIN=1 during the 2nd word for 3 cycles -> word 2 held 4 cycles, order intact, end_transactionOUT at T+9.
- Decode:
  - Begin at 0x6000_0000 -> no output activity, memory unchanged.
  - Read at 0x5000_07FC, burst_size=1 (crosses the end of the default window) -> errorOUT=1 at T+1 only, no data_validOUT.
- Abort: end_transactionIN during word 1 of an 8-word read -> data_validOUT=0 next cycle, no end_transactionOUT; a following read works.
